// File: rtl/spy_pkg.sv
// Shared types and constants for the spy-buffer capture controller.
package spy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_ARMED,
    S_POST,
    S_FULL
  } state_e;

  localparam int DEF_ADDR_W      = 11;
  localparam int DEF_PRE_SAMPLES = 256;

  // Samples written from the trigger sample onward so a capture fills the RAM exactly once.
  function automatic int post_samples(input int addr_w, input int pre);
    return (1 << addr_w) - pre;
  endfunction

endpackage

// File: rtl/spy_capture_ctrl.sv
// Write-side controller for a circular spy RAM: pre-trigger fill, trigger accept,
// fixed post-trigger run, then freeze and report the oldest-sample address.
module spy_capture_ctrl
  import spy_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int PRE_SAMPLES = DEF_PRE_SAMPLES,
  parameter int TCNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_in,
  output logic              wren,
  output logic [ADDR_W-1:0] waddr,
  output logic              b_full,
  output logic              busy,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              trig_early,
  output logic [TCNT_W-1:0] trig_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  if (PRE_SAMPLES < 0 || PRE_SAMPLES >= DEPTH) begin : g_bad_pre
    $error("spy_capture_ctrl: PRE_SAMPLES must lie in 0..DEPTH-1");
  end

  localparam logic [CW-1:0]     PRE_C  = CW'(PRE_SAMPLES);
  localparam logic [CW-1:0]     POST_C = CW'(post_samples(ADDR_W, PRE_SAMPLES));
  localparam logic [ADDR_W-1:0] PRE_A  = ADDR_W'(PRE_SAMPLES);

  state_e              state_q;
  logic                wren_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic                b_full_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   trig_addr_q;
  logic [ADDR_W-1:0]   start_addr_q;
  logic                trig_early_q;
  logic [TCNT_W-1:0]   trig_cnt_q;
  logic [CW-1:0]       pre_cnt_q;
  logic [CW-1:0]       post_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wren_q       <= 1'b0;
      waddr_q      <= '0;
      b_full_q     <= 1'b0;
      busy_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      trig_early_q <= 1'b0;
      trig_cnt_q   <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
    end else if (abort) begin
      state_q  <= S_IDLE;
      wren_q   <= 1'b0;
      b_full_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_FULL: begin
          // trig_in is dropped here, including when it coincides with arm
          if (arm) begin
            state_q      <= (PRE_SAMPLES == 0) ? S_ARMED : S_PRETRIG;
            wren_q       <= 1'b1;
            waddr_q      <= '0;
            pre_cnt_q    <= '0;
            trig_early_q <= 1'b0;
            b_full_q     <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        S_PRETRIG: begin
          waddr_q   <= waddr_q + ADDR_W'(1);
          pre_cnt_q <= pre_cnt_q + CW'(1);
          if (trig_in) trig_early_q <= 1'b1;
          if (pre_cnt_q == PRE_C - CW'(1)) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (trig_in) begin
            trig_addr_q <= waddr_q;
            trig_cnt_q  <= trig_cnt_q + TCNT_W'(1);
            post_cnt_q  <= CW'(1);
            if (POST_C == CW'(1)) begin
              state_q      <= S_FULL;
              wren_q       <= 1'b0;
              b_full_q     <= 1'b1;
              busy_q       <= 1'b0;
              start_addr_q <= waddr_q - PRE_A;
            end else begin
              state_q <= S_POST;
              waddr_q <= waddr_q + ADDR_W'(1);
            end
          end else begin
            waddr_q <= waddr_q + ADDR_W'(1);
          end
        end
        S_POST: begin
          // Last write leaves waddr on the final address written
          if (post_cnt_q == POST_C - CW'(1)) begin
            state_q      <= S_FULL;
            wren_q       <= 1'b0;
            b_full_q     <= 1'b1;
            busy_q       <= 1'b0;
            start_addr_q <= trig_addr_q - PRE_A;
          end else begin
            post_cnt_q <= post_cnt_q + CW'(1);
            waddr_q    <= waddr_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          wren_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wren       = wren_q;
  assign waddr      = waddr_q;
  assign b_full     = b_full_q;
  assign busy       = busy_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign trig_early = trig_early_q;
  assign trig_cnt   = trig_cnt_q;

endmodule

// File: tb/tb_spy_capture_ctrl.sv
// Self-checking bench for spy_capture_ctrl at DEPTH=16 with PRE_SAMPLES=4 and PRE_SAMPLES=0.
module tb_spy_capture_ctrl;

  logic        clk;
  logic        reset;
  logic        arm, abort, trig_in;
  logic        wren, b_full, busy, trig_early;
  logic [3:0]  waddr, trig_addr, start_addr;
  logic [15:0] trig_cnt;

  logic        arm0, abort0, trig0;
  logic        wren0, b_full0, busy0, trig_early0;
  logic [3:0]  waddr0, trig_addr0, start_addr0;
  logic [15:0] trig_cnt0;

  int checks = 0;
  int errors = 0;

  int sb_q[$];
  logic sb_en = 1'b0;

  spy_capture_ctrl #(.ADDR_W(4), .PRE_SAMPLES(4), .TCNT_W(16)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig_in(trig_in),
    .wren(wren), .waddr(waddr), .b_full(b_full), .busy(busy),
    .trig_addr(trig_addr), .start_addr(start_addr),
    .trig_early(trig_early), .trig_cnt(trig_cnt)
  );

  spy_capture_ctrl #(.ADDR_W(4), .PRE_SAMPLES(0), .TCNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .arm(arm0), .abort(abort0), .trig_in(trig0),
    .wren(wren0), .waddr(waddr0), .b_full(b_full0), .busy(busy0),
    .trig_addr(trig_addr0), .start_addr(start_addr0),
    .trig_early(trig_early0), .trig_cnt(trig_cnt0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every RAM write of the main instance must match the next expected address.
  always @(negedge clk) begin
    if (sb_en && wren) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra_write actual %0d required none", waddr);
      end else begin
        chk("sb_waddr", {28'd0, waddr}, sb_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        arm, trig;
    logic        wren;
    logic [3:0]  waddr;
    logic        bfull, busy, early;
    logic [3:0]  taddr;
    logic [15:0] tcnt;
    logic [3:0]  saddr;
    logic        sa_chk;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic a, logic t, logic w, int ad, logic bf, logic bz,
                              int ta, int tc, int sa, logic sc);
    vec_t v;
    v.arm = a; v.trig = t; v.wren = w; v.waddr = 4'(ad);
    v.bfull = bf; v.busy = bz; v.early = 1'b0;
    v.taddr = 4'(ta); v.tcnt = 16'(tc); v.saddr = 4'(sa); v.sa_chk = sc;
    return v;
  endfunction

  task automatic wait_addr(input int addr);
    int n = 0;
    while (!(wren && waddr == 4'(addr)) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_addr_timeout", {31'd0, n < 64}, 1);
  endtask

  task automatic wait_full();
    int n = 0;
    while (!b_full && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_full_timeout", {31'd0, n < 64}, 1);
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
    arm0 = 1'b0; abort0 = 1'b0; trig0 = 1'b0;

    // Scenario 1/2 vectors: arm at row 0, trigger applied while waddr=9 is displayed
    vecs[0] = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) vecs[i] = mk(0, 0, 1, i, 0, 1, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 1, 10, 0, 1, 9, 1, 0, 0);
    for (int i = 11; i <= 20; i++) vecs[i] = mk(0, 0, 1, (i) % 16, 0, 1, 9, 1, 0, 0);
    vecs[21] = mk(0, 0, 0, 4, 1, 0, 9, 1, 5, 1);

    repeat (2) @(negedge clk);
    chk("rst_wren", {31'd0, wren}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_bfull", {31'd0, b_full}, 0);
    chk("rst_waddr", {28'd0, waddr}, 0);
    chk("rst_tcnt", {16'd0, trig_cnt}, 0);
    reset = 1'b0;

    for (int r = 0; r < 22; r++) begin
      arm = vecs[r].arm;
      trig_in = vecs[r].trig;
      @(negedge clk);
      arm = 1'b0;
      trig_in = 1'b0;
      chk($sformatf("v%0d_wren", r), {31'd0, wren}, {31'd0, vecs[r].wren});
      chk($sformatf("v%0d_waddr", r), {28'd0, waddr}, {28'd0, vecs[r].waddr});
      chk($sformatf("v%0d_bfull", r), {31'd0, b_full}, {31'd0, vecs[r].bfull});
      chk($sformatf("v%0d_busy", r), {31'd0, busy}, {31'd0, vecs[r].busy});
      chk($sformatf("v%0d_early", r), {31'd0, trig_early}, {31'd0, vecs[r].early});
      chk($sformatf("v%0d_taddr", r), {28'd0, trig_addr}, {28'd0, vecs[r].taddr});
      chk($sformatf("v%0d_tcnt", r), {16'd0, trig_cnt}, {16'd0, vecs[r].tcnt});
      if (vecs[r].sa_chk)
        chk($sformatf("v%0d_saddr", r), {28'd0, start_addr}, {28'd0, vecs[r].saddr});
    end

    // Scenario 5: re-arm from FULL, trigger on the first ARMED write
    for (int a = 0; a < 16; a++) sb_q.push_back(a);
    sb_en = 1'b1;
    pulse_arm();
    chk("rearm_bfull", {31'd0, b_full}, 0);
    chk("rearm_wren", {31'd0, wren}, 1);
    chk("rearm_waddr", {28'd0, waddr}, 0);
    chk("rearm_early", {31'd0, trig_early}, 0);
    wait_addr(4);
    pulse_trig();
    wait_full();
    chk("cap2_tcnt", {16'd0, trig_cnt}, 2);
    chk("cap2_taddr", {28'd0, trig_addr}, 4);
    chk("cap2_saddr", {28'd0, start_addr}, 0);
    chk("cap2_waddr_hold", {28'd0, waddr}, 15);
    chk("cap2_wren", {31'd0, wren}, 0);
    sb_en = 1'b0;
    chk("cap2_sb_empty", sb_q.size(), 0);

    // Scenario 3: early trigger in PRETRIG is flagged, later trigger completes
    for (int a = 0; a < 16; a++) sb_q.push_back(a);
    for (int a = 0; a < 3; a++) sb_q.push_back(a);
    sb_en = 1'b1;
    pulse_arm();
    wait_addr(2);
    pulse_trig();
    chk("early_flag", {31'd0, trig_early}, 1);
    chk("early_tcnt", {16'd0, trig_cnt}, 2);
    chk("early_busy", {31'd0, busy}, 1);
    wait_addr(7);
    pulse_trig();
    chk("cap3_tcnt_now", {16'd0, trig_cnt}, 3);
    wait_full();
    chk("cap3_taddr", {28'd0, trig_addr}, 7);
    chk("cap3_saddr", {28'd0, start_addr}, 3);
    chk("cap3_early_sticky", {31'd0, trig_early}, 1);
    chk("cap3_waddr_hold", {28'd0, waddr}, 2);
    sb_en = 1'b0;
    chk("cap3_sb_empty", sb_q.size(), 0);

    // Scenario 4: arm while busy ignored, abort in POST, reset beats arm
    pulse_arm();
    wait_addr(5);
    pulse_arm();
    chk("busy_arm_ignored", {28'd0, waddr}, 6);
    pulse_trig();
    chk("cap4_taddr", {28'd0, trig_addr}, 6);
    chk("cap4_tcnt", {16'd0, trig_cnt}, 4);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_wren", {31'd0, wren}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_bfull", {31'd0, b_full}, 0);
    chk("abort_taddr_hold", {28'd0, trig_addr}, 6);
    chk("abort_saddr_hold", {28'd0, start_addr}, 3);
    chk("abort_tcnt_hold", {16'd0, trig_cnt}, 4);
    pulse_trig();
    chk("idle_trig_ignored", {16'd0, trig_cnt}, 4);
    chk("idle_wren", {31'd0, wren}, 0);
    reset = 1'b1;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("rst_arm_wren", {31'd0, wren}, 0);
    chk("rst_arm_busy", {31'd0, busy}, 0);
    chk("rst_arm_waddr", {28'd0, waddr}, 0);
    chk("rst_arm_taddr", {28'd0, trig_addr}, 0);
    chk("rst_arm_saddr", {28'd0, start_addr}, 0);
    chk("rst_arm_tcnt", {16'd0, trig_cnt}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Scenario 6: PRE_SAMPLES=0, arm together with a held trigger
    arm0 = 1'b1;
    trig0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      arm0 = 1'b0;
      chk($sformatf("p0_wren_%0d", i), {31'd0, wren0}, 1);
      chk($sformatf("p0_waddr_%0d", i), {28'd0, waddr0}, i);
      chk($sformatf("p0_tcnt_%0d", i), {16'd0, trig_cnt0}, (i == 0) ? 0 : 1);
    end
    @(negedge clk);
    trig0 = 1'b0;
    chk("p0_bfull", {31'd0, b_full0}, 1);
    chk("p0_wren_off", {31'd0, wren0}, 0);
    chk("p0_taddr", {28'd0, trig_addr0}, 0);
    chk("p0_saddr", {28'd0, start_addr0}, 0);
    chk("p0_tcnt_final", {16'd0, trig_cnt0}, 1);
    chk("p0_busy", {31'd0, busy0}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spy_capture_ctrl.md
Name: spy_capture_ctrl

Overview:
Write-side controller for a spy (snapshot) buffer RAM with a programmable pre-trigger window.
- Once armed, writes the RAM continuously as a circular buffer.
- Accepts a trigger only after the pre-trigger window is filled.
- After the trigger, writes a fixed number of post-trigger samples, then freezes the buffer and reports the oldest-sample address for readout.
- Sits between the trigger logic and a 2^ADDR_W-deep dual-port spy RAM; the readout side uses start_addr/trig_addr.

Parameters:
ADDR_W, 11, RAM address width; DEPTH = 2^ADDR_W.
PRE_SAMPLES, 256, samples kept before the trigger sample; legal range 0..DEPTH-1 (elaboration error otherwise).
TCNT_W, 16, width of the accepted-trigger counter.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
arm  in  1  start a capture; accepted in IDLE or FULL only.
abort  in  1  return to IDLE and discard the capture.
trig_in  in  1  trigger strobe, level-sampled each cycle.
wren  out  1  RAM write enable.
waddr  out  ADDR_W  RAM write address, valid while wren=1.
b_full  out  1  capture complete, buffer frozen.
busy  out  1  high in PRETRIG, ARMED and POST.
trig_addr  out  ADDR_W  RAM address of the trigger sample.
start_addr  out  ADDR_W  address of the oldest valid sample, (trig_addr - PRE_SAMPLES) mod DEPTH.
trig_early  out  1  sticky: a trigger arrived during PRETRIG.
trig_cnt  out  TCNT_W  accepted triggers since reset; wraps.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset all outputs go to 0 and the state goes to IDLE. Reset has priority over every other input.
- States: IDLE, PRETRIG, ARMED, POST, FULL. All outputs are registered.
- IDLE: wren=0.
  - arm=1 → PRETRIG next cycle, with wren=1, waddr=0, pre_cnt=0, trig_early cleared.
  - trig_in is ignored.
- PRETRIG: wren=1; waddr increments by 1 per cycle, wrapping DEPTH-1 → 0.
  - pre_cnt counts writes. After PRE_SAMPLES writes → ARMED.
  - If PRE_SAMPLES=0, arm goes straight to ARMED (with wren=1, waddr=0).
  - trig_in=1 here is not accepted and sets trig_early=1.
- ARMED: writes continue circularly.
  - trig_in=1 makes the current write the trigger sample: trig_addr <= waddr, trig_cnt += 1, post_cnt=1, next state POST.
  - If POST_SAMPLES = DEPTH - PRE_SAMPLES equals 1, the next state is FULL instead.
- POST: writes continue.
  - Each write increments post_cnt.
  - The write with post_cnt = POST_SAMPLES-1 is the last one. The following cycle: wren=0, b_full=1, state FULL, start_addr = trig_addr - PRE_SAMPLES (mod DEPTH).
  - trig_in is ignored; trig_cnt does not count it.
- Write count per capture: exactly DEPTH writes from the trigger window (PRE_SAMPLES before plus POST_SAMPLES from the trigger sample onward). The buffer then holds addresses start_addr .. start_addr+DEPTH-1 (mod DEPTH), in time order.
- FULL: wren=0; waddr holds its last value.
  - arm=1 → b_full cleared and capture restarts exactly as from IDLE (waddr=0).
  - trig_addr and start_addr are held until the next trigger acceptance.
- abort=1 in any state: next cycle state IDLE, wren=0, b_full=0. trig_addr, start_addr and trig_cnt are held.
- Same-cycle input priority: reset > abort > arm > trig_in.
  - arm while busy is ignored.
  - arm and trig_in together in IDLE/FULL: arm is taken, trigger dropped.
- busy = 1 in PRETRIG, ARMED and POST.
- Arithmetic: all address arithmetic is mod DEPTH. pre_cnt and post_cnt are ADDR_W+1 bits wide.

Decomposition:
- Package spy_pkg holds:
  - the state enum (IDLE, PRETRIG, ARMED, POST, FULL);
  - the default ADDR_W and PRE_SAMPLES constants;
  - a POST_SAMPLES helper function.
- No sub-module: one FSM plus counters, roughly 150–250 lines.

Test Plan:
All scenarios use ADDR_W=4 (DEPTH=16) and PRE_SAMPLES=4 unless stated otherwise.
1. Reset then arm pulse at cycle 0 → wren=1 from cycle 1; waddr 0,1,2,3; state ARMED from cycle 5; busy=1, b_full=0.
2. Continue from 1 with trig_in at waddr=9 → trig_addr=9, trig_cnt=1; writes at addresses 9..15,0..4 (12 writes); next cycle wren=0, b_full=1, start_addr=5.
3. Arm, then trig_in at waddr=2 (in PRETRIG) → trigger not accepted, trig_early=1, trig_cnt unchanged; a later trigger in ARMED completes normally.
4. Abort during POST → next cycle wren=0, busy=0, b_full=0, state IDLE; reset asserted in the same cycle as arm → all outputs stay 0.
5. In FULL, arm pulse → b_full=0 next cycle, wren=1, waddr=0, trig_early=0; a second capture gives trig_cnt=2.
6. PRE_SAMPLES=0, arm with trig_in held high → trigger accepted on the first write: trig_addr=0; 16 writes at addresses 0..15; start_addr=0; then b_full=1.
